// File: rtl/vga_scan_timing_gen_if.sv
// Scan-stream and VGA-pin bundle for vga_scan_timing_gen.
// master = the timing generator, slave = the drawing pipeline / connector side.
interface vga_scan_timing_gen_if;
  logic [7:0]  RGB_in;
  logic        testPattern;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        pixelTick;
  logic        hsyncN;
  logic        vsyncN;
  logic        blankN;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  modport master (
    input  RGB_in, testPattern,
    output pixelX, pixelY, startOfFrame, pixelTick,
    output hsyncN, vsyncN, blankN, red, green, blue
  );

  modport slave (
    output RGB_in, testPattern,
    input  pixelX, pixelY, startOfFrame, pixelTick,
    input  hsyncN, vsyncN, blankN, red, green, blue
  );
endinterface

// File: rtl/vga_scan_timing_gen.sv
// VGA scan counters, pixel-tick divider and sync/blank alignment pipeline.
// Optional colour-bar generator is enabled by defining TEST_PATTERN_EN.
module vga_scan_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  vga_scan_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] Y_SOF    = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
`ifdef TEST_PATTERN_EN
    logic [10:0] x;
`endif
    logic active;
    logic hs;
    logic vs;
  } timing_t;

  logic [1:0]  div;
  logic        tick;
  logic        sof;
  logic [10:0] x;
  logic [10:0] y;
  timing_t     raw;
  timing_t     delayed;
  timing_t     pipe [PIPE_DELAY];
  logic        hsync_q;
  logic        vsync_q;
  logic        blank_q;
  logic [7:0]  rgb_q;
  logic [7:0]  colour;

  // Tick is registered so it stays low while reset is held, even with CLK_DIV=1.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_LAST);
      div  <= (div == DIV_LAST) ? 2'd0 : div + 2'd1;
    end
  end

  // Frame pulse fires as the counters step into the first vertical-blanking line.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x   <= '0;
      y   <= '0;
      sof <= 1'b0;
    end else begin
      sof <= tick && (x == X_LAST) && (y == Y_SOF);
      if (tick) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? 11'd0 : y + 11'd1;
        end else begin
          x <= x + 11'd1;
        end
      end
    end
  end

  always_comb begin
    raw        = '0;
    raw.active = (x < X_ACT) && (y < Y_ACT);
    raw.hs     = (x >= HS_FIRST) && (x <= HS_LAST);
    raw.vs     = (y >= VS_FIRST) && (y <= VS_LAST);
`ifdef TEST_PATTERN_EN
    raw.x      = x;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= '0;
    end else if (tick) begin
      pipe[0] <= raw;
      for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign delayed = pipe[PIPE_DELAY-1];

`ifdef TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
  logic [2:0] bar;
  logic [7:0] bar_colour;

  always_comb begin
    bar = 3'(delayed.x / BAR_W);
    case (bar)
      3'd0:    bar_colour = 8'hFF;
      3'd1:    bar_colour = 8'hFC;
      3'd2:    bar_colour = 8'h1F;
      3'd3:    bar_colour = 8'h1C;
      3'd4:    bar_colour = 8'hE3;
      3'd5:    bar_colour = 8'hE0;
      3'd6:    bar_colour = 8'h03;
      default: bar_colour = 8'h00;
    endcase
    colour = bus.testPattern ? bar_colour : bus.RGB_in;
  end
`else
  logic unused_test_pattern;
  assign unused_test_pattern = bus.testPattern;
  assign colour = bus.RGB_in;
`endif

  // Outside the delayed visible window the pins are forced black whatever arrives.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= 8'h00;
    end else if (tick) begin
      hsync_q <= ~delayed.hs;
      vsync_q <= ~delayed.vs;
      blank_q <= delayed.active;
      rgb_q   <= delayed.active ? colour : 8'h00;
    end
  end

  assign bus.pixelX       = x;
  assign bus.pixelY       = y;
  assign bus.startOfFrame = sof;
  assign bus.pixelTick    = tick;
  assign bus.hsyncN       = hsync_q;
  assign bus.vsyncN       = vsync_q;
  assign bus.blankN       = blank_q;
  assign bus.red          = {rgb_q[7:5], rgb_q[7]};
  assign bus.green        = {rgb_q[4:2], rgb_q[4]};
  assign bus.blue         = {rgb_q[1:0], rgb_q[1:0]};
endmodule
